// File: rtl/tt_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and counter sizing.
package tt_sub_pkg;

    localparam int unsigned MAX_WIDTH = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Counter must hold values 0..w
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/tt_full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin, with borrow-out.
module tt_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell plus a borrow flop.
import tt_sub_pkg::*;

module tt_um_serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_c;
    logic             bout_c;
    logic             start_c;

    assign start_c = uio_in[0];

    tt_full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bw_q),
        .d    (d_c),
        .bout (bout_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    a_d     = ui_in[WIDTH-1:0];
                    b_d     = ui_in[4 +: WIDTH];
                    bw_d    = uio_in[1];
                    cnt_d   = '0;
                    diff_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                diff_d = (diff_q >> 1) | (WIDTH'(d_c) << (WIDTH - 1));
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                bw_d   = bout_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A held start level must not retrigger
                if (!start_c) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uo_out  = {1'b0, done_q, busy_q, bw_q, 4'(diff_q)};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:2], ui_in};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Directed bench for the bit-serial subtractor, checked with immediate assertions.
module tb_tt_um_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    tt_um_serial_subtractor #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start pulse on edge 0, result expected after edge 4, then back to IDLE
    task automatic run_op(input string tag, input logic [7:0] ops, input logic bin,
                          input logic [7:0] exp);
        ui_in  = ops;
        uio_in = {6'b0, bin, 1'b1};
        tick();
        uio_in = {6'b0, bin, 1'b0};
        repeat (4) tick();
        check({tag, "_done"}, uo_out, exp);
        tick();
        check({tag, "_idle"}, uo_out, exp & 8'hBF);
    endtask

    initial begin
        int busy_cycles;
        logic [4:0] ref_res;

        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        repeat (2) tick();
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", uo_out, 8'h00);

        run_op("a9_b3", 8'h39, 1'b0, 8'h46);
        run_op("a0_b0_bin1", 8'h00, 1'b1, 8'h5F);
        run_op("af_bf", 8'hFF, 1'b0, 8'h40);

        // Busy must be high for exactly four sampled cycles
        ui_in  = 8'h93;
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (uo_out[5]) busy_cycles++;
            if (uo_out[6]) break;
            tick();
        end
        check("busy_cycles", 8'(busy_cycles), 8'd4);
        check("a3_b9_done", uo_out, 8'h5A);
        tick();
        check("a3_b9_idle", uo_out, 8'h1A);

        // Reset during the second shift cycle clears outputs without waiting for a clock
        ui_in  = 8'hFF;
        uio_in = 8'h03;
        tick();
        uio_in = 8'h00;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_shift", uo_out, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("after_reset_a9_b3", 8'h39, 1'b0, 8'h46);

        // Held start across DONE, operands changed during shift
        ui_in  = 8'h5A;
        uio_in = 8'h03;
        tick();
        ui_in = 8'hFF;
        uio_in = 8'h01;
        repeat (4) tick();
        check("held_start_result", uo_out, 8'h44);
        for (int i = 0; i < 10; i++) tick();
        check("held_start_no_retrigger", uo_out, 8'h44);
        uio_in = 8'h00;
        tick();
        check("held_start_release", uo_out, 8'h04);

        // All operand pairs and borrow-in values against an arithmetic reference
        for (int bin = 0; bin < 2; bin++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    ref_res = 5'({1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(bin));
                    run_op("sweep", {4'(b), 4'(a)}, 1'(bin), {3'b010, ref_res});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
